otter_ctrl_fsm: RTL and testbench

Multicycle control state machine for the OTTER core. It drives the FSM side of `control_if`: it sequences each instruction through fetch, execute and load write-back, and produces the architectural write enables and memory read strobes. It sits beside the combinational decoder, shares the `opcode` field with it, and adds a memory-ready wait handshake, an illegal-opcode flag and a retired-instruction counter.

---
 rtl/otter_ctrl_fsm.sv | 176 +++++++++++++++++
 tb/tb_otter_ctrl_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/otter_ctrl_fsm.sv
// otter_ctrl_fsm: multicycle control sequencer for the OTTER core.
// Steps each instruction through FETCH -> EXEC (-> WB for loads), waits on
// mem_rdy for memory reads, flags unsupported opcodes and counts retirements.
// Strobes are decoded combinationally from the current state, opcode and
// mem_rdy so the datapath sees them in the same cycle; state, illegal and
// instret are flops.

module otter_ctrl_fsm #(
    parameter int unsigned INIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        mem_rdy,
    output logic        reset,
    output logic        pc_we,
    output logic        rf_we,
    output logic        mem_we,
    output logic        mem_re1,
    output logic        mem_re2,
    output logic [1:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned KIND_W  = 3;

    // RV32I base opcodes handled by this core
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    // Debug-visible state encoding
    localparam logic [STATE_W-1:0] ST_INIT  = 2'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 2'd1;
    localparam logic [STATE_W-1:0] ST_EXEC  = 2'd2;
    localparam logic [STATE_W-1:0] ST_WB    = 2'd3;

    // Instruction classes as seen by the sequencer
    localparam logic [KIND_W-1:0] K_REGWR = 3'd0;  // writes PC and RF
    localparam logic [KIND_W-1:0] K_BR    = 3'd1;  // writes PC only
    localparam logic [KIND_W-1:0] K_ST    = 3'd2;  // memory write + PC
    localparam logic [KIND_W-1:0] K_LD    = 3'd3;  // memory read, needs WB
    localparam logic [KIND_W-1:0] K_ILL   = 3'd4;  // unsupported, skipped

    // Last value of the init counter before leaving INIT
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    logic [STATE_W-1:0] state_q,    state_d;
    logic [CNT_W-1:0]   init_cnt_q, init_cnt_d;
    logic               illegal_q,  illegal_d;
    logic [XLEN-1:0]    instret_q,  instret_d;
    logic [KIND_W-1:0]  kind;
    logic               retire;

    // Classify the opcode into the handful of behaviours the sequencer cares about
    always_comb begin
        kind = K_ILL;
        case (opcode)
            OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: kind = K_REGWR;
            OP_BRANCH:                                         kind = K_BR;
            OP_STORE:                                          kind = K_ST;
            OP_LOAD:                                           kind = K_LD;
            default:                                           kind = K_ILL;
        endcase
    end

    // Next-state, bookkeeping and strobe decode
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        reset      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        mem_we     = 1'b0;
        mem_re1    = 1'b0;
        mem_re2    = 1'b0;

        case (state_q)
            ST_INIT: begin
                reset = 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_FETCH;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end

            ST_FETCH: begin
                // Instruction read held until memory answers
                mem_re1 = 1'b1;
                if (mem_rdy) begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                case (kind)
                    K_REGWR: begin
                        pc_we  = 1'b1;
                        rf_we  = 1'b1;
                        retire = 1'b1;
                    end
                    K_BR: begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                    K_ST: begin
                        mem_we = 1'b1;
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                    K_LD: begin
                        mem_re2 = 1'b1;
                        state_d = ST_WB;
                    end
                    default: begin
                        // Skip over the unsupported instruction and remember it
                        pc_we     = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end

            ST_WB: begin
                // Data read held until memory answers, then commit the load
                mem_re2 = 1'b1;
                if (mem_rdy) begin
                    rf_we   = 1'b1;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase

        instret_d = instret_q + XLEN'(retire);
    end

    // State and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            illegal_q  <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            illegal_q  <= illegal_d;
            instret_q  <= instret_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_otter_ctrl_fsm.sv
// Bench for otter_ctrl_fsm: per-instruction expected cycle sequences are
// built from the instruction rules, checked on every falling edge.
module tb_otter_ctrl_fsm;

    localparam int unsigned INIT_N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        mem_rdy;
    logic        reset, pc_we, rf_we, mem_we, mem_re1, mem_re2;
    logic [1:0]  state;
    logic        illegal;
    logic [31:0] instret;

    otter_ctrl_fsm #(.INIT_CYCLES(INIT_N)) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .mem_rdy (mem_rdy),
        .reset   (reset),
        .pc_we   (pc_we),
        .rf_we   (rf_we),
        .mem_we  (mem_we),
        .mem_re1 (mem_re1),
        .mem_re2 (mem_re2),
        .state   (state),
        .illegal (illegal),
        .instret (instret)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs for the current cycle
    logic [1:0]  e_state;
    logic        e_reset, e_pw, e_rw, e_mw, e_re1, e_re2, e_ill;
    logic [31:0] e_instret;
    logic        chk_en = 1'b0;

    // Architectural model: retired count and sticky illegal, plus effects
    // that land on the next rising edge
    logic [31:0] m_ret;
    logic        m_ill;
    logic        p_ret, p_ill;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Compare DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",   32'(state),   32'(e_state));
            chk("reset",   32'(reset),   32'(e_reset));
            chk("pc_we",   32'(pc_we),   32'(e_pw));
            chk("rf_we",   32'(rf_we),   32'(e_rw));
            chk("mem_we",  32'(mem_we),  32'(e_mw));
            chk("mem_re1", 32'(mem_re1), 32'(e_re1));
            chk("mem_re2", 32'(mem_re2), 32'(e_re2));
            chk("illegal", 32'(illegal), 32'(e_ill));
            chk("instret", instret,      e_instret);
        end
    end

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67: return 0;
            7'h63: return 1;
            7'h23: return 2;
            7'h03: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [6:0] rnd_op();
        logic [6:0] tbl [10];
        tbl = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h23, 7'h03, 7'h7F};
        if ($urandom_range(0, 4) == 0) return 7'($urandom_range(0, 127));
        return tbl[$urandom_range(0, 9)];
    endfunction

    task automatic set_reset_exp();
        e_state = 2'd0; e_reset = 1'b1; e_pw = 1'b0; e_rw = 1'b0; e_mw = 1'b0;
        e_re1 = 1'b0; e_re2 = 1'b0; e_ill = 1'b0; e_instret = 32'd0;
        m_ret = 32'd0; m_ill = 1'b0; p_ret = 1'b0; p_ill = 1'b0;
    endtask

    // One clock cycle: drive inputs, publish expectations, queue edge effects
    task automatic cycle(input logic [6:0] op, input logic rdy, input logic rel,
                         input logic [1:0] st, input logic r, input logic pw,
                         input logic rw, input logic mw, input logic re1,
                         input logic re2, input logic ret, input logic sill);
        @(posedge clk);
        #1;
        m_ret = m_ret + 32'(p_ret);
        m_ill = m_ill | p_ill;
        if (rel) rst = 1'b1;
        opcode  = op;
        mem_rdy = rdy;
        e_state = st; e_reset = r; e_pw = pw; e_rw = rw; e_mw = mw;
        e_re1 = re1; e_re2 = re2; e_ill = m_ill; e_instret = m_ret;
        p_ret = ret; p_ill = sill;
    endtask

    task automatic init_seq();
        cycle(7'h00, 1'b1, 1'b1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < int'(INIT_N); i++)
            cycle(7'h00, 1'b1, 1'b0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Full instruction with fw fetch stalls and ww write-back stalls
    task automatic run_instr(input logic [6:0] op, input int fw, input int ww);
        int k;
        for (int i = 0; i <= fw; i++)
            cycle(rnd_op(), 1'(i == fw), 1'b0, 2'd1, 0, 0, 0, 0, 1, 0, 0, 0);
        k = kind_of(op);
        case (k)
            0: cycle(op, 1'($urandom_range(0, 1)), 1'b0, 2'd2, 0, 1, 1, 0, 0, 0, 1, 0);
            1: cycle(op, 1'($urandom_range(0, 1)), 1'b0, 2'd2, 0, 1, 0, 0, 0, 0, 1, 0);
            2: cycle(op, 1'($urandom_range(0, 1)), 1'b0, 2'd2, 0, 1, 0, 1, 0, 0, 1, 0);
            3: begin
                cycle(op, 1'($urandom_range(0, 1)), 1'b0, 2'd2, 0, 0, 0, 0, 0, 1, 0, 0);
                for (int i = 0; i <= ww; i++)
                    cycle(op, 1'(i == ww), 1'b0, 2'd3, 0, 1'(i == ww), 1'(i == ww),
                          0, 0, 1, 1'(i == ww), 0);
            end
            default: cycle(op, 1'($urandom_range(0, 1)), 1'b0, 2'd2, 0, 1, 0, 0, 0, 0, 0, 1);
        endcase
    endtask

    // Extra FETCH wait cycle followed by a literal check of instret
    task automatic stall_check(input string nm, input logic [31:0] v);
        cycle(rnd_op(), 1'b0, 1'b0, 2'd1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk(nm, instret, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; mem_rdy = 1'b1; opcode = 7'h00;
        set_reset_exp();
        #2;
        chk("rst_reset_lit",   32'(reset),   32'd1);
        chk("rst_state_lit",   32'(state),   32'd0);
        chk("rst_instret_lit", instret,      32'd0);
        chk("rst_strobes_lit", 32'({pc_we, rf_we, mem_we, mem_re1, mem_re2}), 32'd0);
        chk_en = 1'b1;
        repeat (2) cycle(7'h00, 1'b1, 1'b0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        init_seq();

        // Three OP_IMM back to back
        repeat (3) run_instr(7'h13, 0, 0);
        stall_check("instret_after_3_opimm", 32'd3);

        // Load with two write-back stalls
        run_instr(7'h03, 0, 2);
        stall_check("instret_after_load", 32'd4);

        // Store, then an unsupported opcode
        run_instr(7'h23, 0, 0);
        run_instr(7'h7F, 0, 0);
        stall_check("instret_after_illegal", 32'd5);
        chk("illegal_lit", 32'(illegal), 32'd1);

        // Randomized instruction stream with random stalls
        for (int n = 0; n < 60; n++)
            run_instr(rnd_op(), $urandom_range(0, 2), $urandom_range(0, 2));

        // Asynchronous reset during a stalled write-back
        cycle(rnd_op(), 1'b1, 1'b0, 2'd1, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle(7'h03, 1'b1, 1'b0, 2'd2, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(7'h03, 1'b0, 1'b0, 2'd3, 0, 0, 0, 0, 0, 1, 0, 0);
        #6;
        rst = 1'b0;
        set_reset_exp();
        #1;
        chk("async_reset_lit",   32'(reset),   32'd1);
        chk("async_state_lit",   32'(state),   32'd0);
        chk("async_strobes_lit", 32'({pc_we, rf_we, mem_we, mem_re1, mem_re2}), 32'd0);
        chk("async_instret_lit", instret,      32'd0);
        chk("async_illegal_lit", 32'(illegal), 32'd0);
        repeat (2) cycle(7'h00, 1'b0, 1'b0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        init_seq();

        // Counter wrap: preload all-ones, then retire one branch
        cycle(rnd_op(), 1'b0, 1'b0, 2'd1, 0, 0, 0, 0, 1, 0, 0, 0);
        force dut.instret_q = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        e_instret = m_ret;
        cycle(rnd_op(), 1'b0, 1'b0, 2'd1, 0, 0, 0, 0, 1, 0, 0, 0);
        release dut.instret_q;
        run_instr(7'h63, 0, 0);
        stall_check("instret_wrap", 32'd0);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
